exec_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the integer core. It fetches an instruction over a req/ack port and decodes its opcode. It drives the immediate sign-extender format select (extnr_ops) and the ALU, register-file, PC and data-memory strobes through FETCH, DECODE, EXEC, MEM and WB. It sits between the instruction register/PC and the datapath (sign-extender, ALU, register file, LSU).

---
 rtl/exec_ctrl_fsm.sv | 131 +++++++++++++
 tb/tb_exec_ctrl_fsm.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/exec_ctrl_fsm.sv
// exec_ctrl_fsm: multi-cycle fetch/decode/exec/mem/wb sequencer with bus timeout and sticky error flags
module exec_ctrl_fsm #(
   parameter int WORDSIZE = 32,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   input  logic                imem_ack,
   input  logic [WORDSIZE-1:0] imem_rdata,
   output logic                ir_we,
   output logic [WORDSIZE-1:0] instr,
   output logic [1:0]          extnr_ops,
   output logic                alu_src_imm,
   output logic [1:0]          alu_op,
   input  logic                branch_taken,
   output logic                pc_we,
   output logic                pc_sel,
   output logic                dmem_req,
   output logic                dmem_we,
   input  logic                dmem_ack,
   output logic                reg_we,
   output logic                wb_sel,
   output logic                illegal,
   output logic                bus_err,
   output logic [2:0]          state
);
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   state_t st;
   logic [7:0] cnt;
   logic is_op, is_opi, is_ld, is_st, is_br, legal, tmo;
   assign is_op  = instr[6:0] == 7'b0110011;
   assign is_opi = instr[6:0] == 7'b0010011;
   assign is_ld  = instr[6:0] == 7'b0000011;
   assign is_st  = instr[6:0] == 7'b0100011;
   assign is_br  = instr[6:0] == 7'b1100011;
   assign legal  = is_op | is_opi | is_ld | is_st | is_br;
   assign tmo    = cnt == 8'(TIMEOUT - 1);
   assign state  = st;
   // Ack-qualified strobes are combinational so they line up with the ack cycle
   always_comb begin
      ir_we  = st == FETCH && imem_req && imem_ack;
      pc_sel = st == EXEC && is_br && branch_taken;
      pc_we  = (st == DECODE && !legal) || (st == EXEC && is_br) ||
               (st == MEM && is_st && dmem_ack) || st == WB;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= FETCH;
         instr       <= '0;
         extnr_ops   <= 2'd0;
         alu_src_imm <= 1'b0;
         alu_op      <= 2'd0;
         imem_req    <= 1'b0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         reg_we      <= 1'b0;
         wb_sel      <= 1'b0;
         illegal     <= 1'b0;
         bus_err     <= 1'b0;
         cnt         <= 8'd0;
      end else begin
         case (st)
            FETCH:
               if (imem_req && imem_ack) begin
                  instr    <= imem_rdata;
                  imem_req <= 1'b0;
                  cnt      <= 8'd0;
                  st       <= DECODE;
               end else if (imem_req && tmo) begin
                  bus_err  <= 1'b1;
                  imem_req <= 1'b0;
                  cnt      <= 8'd0;
                  st       <= HALT;
               end else begin
                  imem_req <= 1'b1;
                  if (imem_req) cnt <= cnt + 8'd1;
               end
            DECODE:
               if (legal) begin
                  extnr_ops   <= is_br ? 2'd3 : is_st ? 2'd2 : (is_opi | is_ld) ? 2'd1 : 2'd0;
                  alu_src_imm <= !(is_op | is_br);
                  alu_op      <= is_br ? 2'd1 : (is_op | is_opi) ? 2'd2 : 2'd0;
                  st          <= EXEC;
               end else begin
                  illegal  <= 1'b1;
                  imem_req <= 1'b1;
                  st       <= FETCH;
               end
            EXEC:
               if (is_ld || is_st) begin
                  dmem_req <= 1'b1;
                  dmem_we  <= is_st;
                  st       <= MEM;
               end else if (is_br) begin
                  imem_req <= 1'b1;
                  st       <= FETCH;
               end else begin
                  reg_we <= 1'b1;
                  wb_sel <= 1'b0;
                  st     <= WB;
               end
            MEM:
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  cnt      <= 8'd0;
                  reg_we   <= is_ld;
                  wb_sel   <= is_ld;
                  imem_req <= !is_ld;
                  st       <= is_ld ? WB : FETCH;
               end else if (tmo) begin
                  bus_err  <= 1'b1;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  cnt      <= 8'd0;
                  st       <= HALT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            WB: begin
               reg_we   <= 1'b0;
               wb_sel   <= 1'b0;
               imem_req <= 1'b1;
               st       <= FETCH;
            end
            default: st <= HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_exec_ctrl_fsm.sv
// tb_exec_ctrl_fsm: directed instruction stream with a per-event scoreboard on the control strobes
module tb_exec_ctrl_fsm;
   localparam logic [31:0] ADD = 32'h003100B3, LW = 32'h00012083, SW = 32'h00112223;
   localparam logic [31:0] BEQ = 32'h00000463, ILL = 32'h0000007F;
   logic clk = 1'b0, rst_n = 1'b0;
   logic imem_req, imem_ack = 1'b0, ir_we, alu_src_imm, branch_taken = 1'b0, pc_we, pc_sel;
   logic dmem_req, dmem_we, dmem_ack = 1'b0, reg_we, wb_sel, illegal, bus_err;
   logic [31:0] imem_rdata = '0, instr;
   logic [1:0] extnr_ops, alu_op;
   logic [2:0] state;
   int errs = 0, checks = 0, cyc = 0, last = 0;
   logic [24:0] q[$];
   logic [24:0] a, e;
   always #5 clk = ~clk;
   exec_ctrl_fsm #(.WORDSIZE(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir_we(ir_we), .instr(instr), .extnr_ops(extnr_ops), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
      .branch_taken(branch_taken), .pc_we(pc_we), .pc_sel(pc_sel), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_ack(dmem_ack), .reg_we(reg_we), .wb_sel(wb_sel),
      .illegal(illegal), .bus_err(bus_err), .state(state));
   // Event fields: cycles since previous event, state, strobes, decode regs, illegal
   function automatic logic [24:0] ev(int dc, int st, bit ir, bit iw, bit dr, bit dw, bit pw,
                                      bit ps, bit rw, bit ws, int ex, bit im, int op, bit il);
      return {8'(dc), 3'(st), ir, iw, dr, dw, pw, ps, rw, ws, 2'(ex), im, 2'(op), il};
   endfunction
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) last = cyc;
      else if (imem_req | ir_we | dmem_req | pc_we | reg_we) begin
         a = ev(cyc - last, int'(state), imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we,
                wb_sel, int'(extnr_ops), alu_src_imm, int'(alu_op), illegal);
         last = cyc;
         checks++;
         if (q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_event: got %h, want no event (cycle %0d)", a, cyc);
         end else begin
            e = q.pop_front();
            if (a !== e) begin
               errs++;
               $display("FAIL trace: got %h want %h (cycle %0d)", a, e, cyc);
            end
         end
      end
   end
   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", n, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #2;
   endtask
   task automatic do_fetch(input logic [31:0] d, input logic bt);
      int n = 0;
      while (!imem_req && n < 20) begin step(); n++; end
      chk("fetch_req_seen", {31'd0, imem_req}, 32'd1);
      imem_ack = 1'b1;
      imem_rdata = d;
      branch_taken = bt;
      step();
      imem_ack = 1'b0;
   endtask
   task automatic do_mem(input int waits);
      int n = 0;
      while (!dmem_req && n < 20) begin step(); n++; end
      chk("mem_req_seen", {31'd0, dmem_req}, 32'd1);
      repeat (waits) step();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
   endtask
   initial begin
      repeat (3) step();
      chk("reset_outputs", {16'd0, state, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we,
          wb_sel, illegal, bus_err, extnr_ops, alu_src_imm, alu_op}, 32'd0);
      chk("reset_instr", instr, 32'd0);
      rst_n = 1'b1;
      q.push_back(ev(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(ev(3, 4, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2, 0));
      do_fetch(ADD, 1'b0);
      chk("instr_add", instr, ADD);
      q.push_back(ev(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
      q.push_back(ev(3, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      repeat (3) q.push_back(ev(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      q.push_back(ev(1, 4, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0));
      do_fetch(LW, 1'b0);
      do_mem(3);
      q.push_back(ev(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      q.push_back(ev(3, 3, 0, 0, 1, 1, 1, 0, 0, 0, 2, 1, 0, 0));
      do_fetch(SW, 1'b0);
      chk("instr_sw", instr, SW);
      do_mem(0);
      q.push_back(ev(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      q.push_back(ev(2, 2, 0, 0, 0, 0, 1, 1, 0, 0, 3, 0, 1, 0));
      do_fetch(BEQ, 1'b1);
      q.push_back(ev(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0));
      q.push_back(ev(2, 2, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 1, 0));
      do_fetch(BEQ, 1'b0);
      q.push_back(ev(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0));
      q.push_back(ev(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 1, 0));
      do_fetch(ILL, 1'b0);
      q.push_back(ev(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1));
      q.push_back(ev(3, 4, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2, 1));
      do_fetch(ADD, 1'b0);
      q.push_back(ev(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
      do_fetch(LW, 1'b0);
      for (int n = 0; n < 20 && !dmem_req; n++) step();
      chk("mem_before_reset", {29'd0, state}, 32'd3);
      #1 rst_n = 1'b0;
      #1;
      chk("async_dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("async_state", {29'd0, state}, 32'd0);
      chk("async_illegal", {31'd0, illegal}, 32'd0);
      q.push_back(ev(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (7) q.push_back(ev(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
      rst_n = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = ILL;
      #1;
      chk("stale_ack_ir_we", {31'd0, ir_we}, 32'd0);
      chk("req_low_after_release", {31'd0, imem_req}, 32'd0);
      #1 step();
      imem_ack = 1'b0;
      chk("req_next_edge", {31'd0, imem_req}, 32'd1);
      chk("stale_ack_ignored", {29'd0, state}, 32'd0);
      repeat (8) step();
      chk("timeout_state", {29'd0, state}, 32'd5);
      chk("timeout_bus_err", {31'd0, bus_err}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      imem_ack = 1'b1;
      repeat (3) step();
      chk("late_ack_state", {29'd0, state}, 32'd5);
      chk("late_ack_ir_we", {31'd0, ir_we}, 32'd0);
      imem_ack = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("reset_clears_bus_err", {31'd0, bus_err}, 32'd0);
      step();
      chk("queue_drained", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
